// File: rtl/fp_convert_ctrl.sv
// fp_convert_ctrl: serial 12-bit two's-complement to {S,E,F} float sequencer.
// One normalising shift per cycle, round-half-up, valid/ready on both sides.
module fp_convert_ctrl #(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  D2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             S,
  output logic [EXP_W-1:0] E,
  output logic [SIG_W-1:0] F,
  output logic             sat,
  output logic             busy,
  output logic [CNT_W-1:0] conv_cnt
);

  typedef enum logic [2:0] {
    IDLE,
    SIGN,
    NORM,
    ROUND,
    OUT
  } state_t;

  localparam logic [EXP_W-1:0] EMAX = '1;

  state_t            state;
  logic [IN_W-1:0]   smp;
  logic [IN_W-2:0]   mag;
  logic [EXP_W-1:0]  ew;
  logic              sgn;
  logic              sat_m;

  logic [IN_W-2:0]   low;
  logic [IN_W-2:0]   absv;
  logic              minv;
  logic [SIG_W:0]    fsum;

  assign low  = smp[IN_W-2:0];
  assign absv = smp[IN_W-1] ? (~low + 1'b1) : low;
  assign minv = smp[IN_W-1] && (low == '0);

  // Truncated significand plus the first dropped bit; MSB flags a carry-out.
  assign fsum = {1'b0, mag[IN_W-2 -: SIG_W]}
              + {{SIG_W{1'b0}}, mag[IN_W-2-SIG_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      S         <= 1'b0;
      E         <= '0;
      F         <= '0;
      sat       <= 1'b0;
      busy      <= 1'b0;
      conv_cnt  <= '0;
      smp       <= '0;
      mag       <= '0;
      ew        <= '0;
      sgn       <= 1'b0;
      sat_m     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            smp      <= D2;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SIGN;
          end
        end
        SIGN: begin
          sgn   <= smp[IN_W-1];
          sat_m <= minv;
          mag   <= minv ? '1 : absv;
          ew    <= EMAX;
          state <= NORM;
        end
        NORM: begin
          if (mag[IN_W-2] || ew == '0) begin
            state <= ROUND;
          end else begin
            mag <= mag << 1;
            ew  <= ew - 1'b1;
          end
        end
        ROUND: begin
          S <= sgn;
          if (!fsum[SIG_W]) begin
            F   <= fsum[SIG_W-1:0];
            E   <= ew;
            sat <= sat_m;
          end else if (ew != EMAX) begin
            F   <= {1'b1, {(SIG_W-1){1'b0}}};
            E   <= ew + 1'b1;
            sat <= sat_m;
          end else begin
            F   <= '1;
            E   <= EMAX;
            sat <= 1'b1;
          end
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            conv_cnt  <= conv_cnt + 1'b1;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_convert_ctrl.sv
// tb_fp_convert_ctrl: scoreboard bench for fp_convert_ctrl.
// Expected {sat,S,E,F} and latency come from an arithmetic reference model.
module tb_fp_convert_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] D2;
  logic        out_valid;
  logic        out_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        sat;
  logic        busy;
  logic [15:0] conv_cnt;

  always #5 clk = ~clk;

  fp_convert_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .D2        (D2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .sat       (sat),
    .busy      (busy),
    .conv_cnt  (conv_cnt)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [8:0]  exp_q[$];
  int          lat_q[$];
  logic [15:0] cnt_exp;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Value-level reference: leading-one position decides the shift count.
  function automatic logic [8:0] model(input logic [11:0] d,
                                       output int shifts);
    int v, lead, m, e, ft, r, f;
    logic st;
    logic [2:0] eb;
    logic [3:0] fb;
    st = 1'b0;
    v = d[11] ? 4096 - int'(d) : int'(d);
    if (v > 2047) begin
      v  = 2047;
      st = 1'b1;
    end
    lead = -1;
    for (int i = 0; i < 11; i++)
      if (((v >> i) & 1) == 1) lead = i;
    if (lead < 0) shifts = 7;
    else shifts = (10 - lead > 7) ? 7 : 10 - lead;
    e  = 7 - shifts;
    m  = v << shifts;
    ft = (m >> 7) & 15;
    r  = (m >> 6) & 1;
    f  = ft + r;
    if (f == 16) begin
      if (e < 7) begin
        f = 8;
        e = e + 1;
      end else begin
        f  = 15;
        st = 1'b1;
      end
    end
    eb = 3'(e);
    fb = 4'(f);
    return {st, d[11], eb, fb};
  endfunction

  task automatic convert(input logic [11:0] d, input int hold);
    int sh, n;
    logic [8:0] want;
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    exp_q.push_back(model(d, sh));
    lat_q.push_back(3 + sh);
    in_valid = 1'b1;
    D2       = d;
    @(posedge clk); #1;
    // Keep offering junk while busy; it must be ignored.
    D2 = ~d;
    n  = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      chk("busy", 32'(busy), 32'd1);
    end
    in_valid = 1'b0;
    chk("latency", 32'(n), 32'(lat_q.pop_front()));
    want = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_result", 32'({sat, S, E, F}), 32'(want));
      @(posedge clk); #1;
    end
    chk("out_valid", 32'(out_valid), 32'd1);
    chk("result", 32'({sat, S, E, F}), 32'(want));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    cnt_exp++;
    chk("conv_cnt", 32'(conv_cnt), 32'(cnt_exp));
    chk("in_ready_post", 32'(in_ready), 32'd1);
    chk("out_valid_post", 32'(out_valid), 32'd0);
    chk("result_kept", 32'({sat, S, E, F}), 32'(want));
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    D2        = '0;
    cnt_exp   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'({sat, S, E, F}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_conv_cnt", 32'(conv_cnt), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    convert(12'h001, 0);
    convert(12'hFFF, 0);
    convert(12'h02E, 0);
    convert(12'h07D, 0);
    convert(12'h7FF, 0);
    convert(12'h800, 0);
    convert(12'h000, 0);
    convert(12'h155, 5);
    convert(12'hA3C, 0);
    for (int k = 0; k < 6; k++)
      convert(12'($urandom), $urandom_range(0, 2));

    // Reset mid-NORM discards the sample.
    in_valid = 1'b1;
    D2       = 12'h001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    cnt_exp = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_conv_cnt", 32'(conv_cnt), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    chk("abort_no_output", 32'(seen), 32'd0);

    // Counter wrap.
    force dut.conv_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.conv_cnt;
    cnt_exp = 16'hFFFF;
    convert(12'h02E, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
